// File: rtl/sram_port_arbiter.sv
// Single-port SRAM arbiter shared by instruction fetch and data access.
// Fixed data priority with a starvation guard; tracks one outstanding read.
module sram_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                inst_req,
    input  logic [ADDR_W-1:0]   inst_addr,
    output logic                inst_gnt,
    output logic                inst_rvalid,
    output logic [DATA_W-1:0]   inst_rdata,

    input  logic                data_req,
    input  logic [DATA_W/8-1:0] data_wen,
    input  logic [ADDR_W-1:0]   data_addr,
    input  logic [DATA_W-1:0]   data_wdata,
    output logic                data_gnt,
    output logic                data_rvalid,
    output logic [DATA_W-1:0]   data_rdata,

    output logic                sram_en,
    output logic [DATA_W/8-1:0] sram_wen,
    output logic [ADDR_W-1:0]   sram_addr,
    output logic [DATA_W-1:0]   sram_wdata,
    input  logic [DATA_W-1:0]   sram_rdata,

    output logic                stallreq
);

    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] MAX_W = 4'(MAX_WAIT);

    typedef enum logic [1:0] {
        IDLE,
        INST_RD,
        DATA_RD
    } state_e;

    state_e             state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    logic [DATA_W-1:0]  inst_hold_q, inst_hold_d;
    logic [DATA_W-1:0]  data_hold_q, data_hold_d;

    logic               inst_gnt_w;
    logic               data_gnt_w;
    logic               inst_starved;
    logic               data_is_read;

    assign inst_starved = (starve_q >= MAX_W);
    assign data_is_read = (data_wen == '0);

    // Grant selection: data wins unless fetch has waited MAX_WAIT cycles.
    always_comb begin
        inst_gnt_w = 1'b0;
        data_gnt_w = 1'b0;
        if (rst) begin
            unique case (1'b1)
                (inst_req && data_req): begin
                    if (inst_starved) begin
                        inst_gnt_w = 1'b1;
                    end else begin
                        data_gnt_w = 1'b1;
                    end
                end
                (inst_req && !data_req): inst_gnt_w = 1'b1;
                (!inst_req && data_req): data_gnt_w = 1'b1;
                default: ;
            endcase
        end
    end

    assign inst_gnt = inst_gnt_w;
    assign data_gnt = data_gnt_w;

    // SRAM port mux; idle cycles drive all-zero.
    always_comb begin
        sram_en    = inst_gnt_w | data_gnt_w;
        sram_wen   = '0;
        sram_addr  = '0;
        sram_wdata = '0;
        if (data_gnt_w) begin
            sram_wen   = data_wen;
            sram_addr  = data_addr;
            sram_wdata = data_wdata;
        end else if (inst_gnt_w) begin
            sram_wen   = {BE_W{1'b0}};
            sram_addr  = inst_addr;
            sram_wdata = '0;
        end
    end

    // Next outstanding-read state, starvation count and hold capture.
    always_comb begin
        state_d = IDLE;
        if (inst_gnt_w) begin
            state_d = INST_RD;
        end else if (data_gnt_w && data_is_read) begin
            state_d = DATA_RD;
        end

        starve_d = starve_q;
        if (!inst_req || inst_gnt_w) begin
            starve_d = 4'd0;
        end else if (starve_q < MAX_W) begin
            starve_d = starve_q + 4'd1;
        end

        inst_hold_d = inst_hold_q;
        data_hold_d = data_hold_q;
        if (state_q == INST_RD) begin
            inst_hold_d = sram_rdata;
        end
        if (state_q == DATA_RD) begin
            data_hold_d = sram_rdata;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            starve_q    <= 4'd0;
            inst_hold_q <= '0;
            data_hold_q <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            inst_hold_q <= inst_hold_d;
            data_hold_q <= data_hold_d;
        end
    end

    // Read return: route live SRAM data by state, else show the hold copy.
    always_comb begin
        inst_rvalid = 1'b0;
        data_rvalid = 1'b0;
        inst_rdata  = '0;
        data_rdata  = '0;
        if (rst) begin
            inst_rvalid = (state_q == INST_RD);
            data_rvalid = (state_q == DATA_RD);
            inst_rdata  = inst_rvalid ? sram_rdata : inst_hold_q;
            data_rdata  = data_rvalid ? sram_rdata : data_hold_q;
        end
    end

    // Stall whenever a pending request lost arbitration this cycle.
    always_comb begin
        stallreq = 1'b0;
        if (rst) begin
            stallreq = (inst_req & ~inst_gnt_w) | (data_req & ~data_gnt_w);
        end
    end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: SRAM model, reference-memory scoreboard,
// directed corner sequences and a table of arbitration vectors.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_gnt;
    logic        inst_rvalid;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_gnt;
    logic        data_rvalid;
    logic [31:0] data_rdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic        stallreq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_port_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
        .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt),
        .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata),
        .stallreq(stallreq)
    );

    logic [31:0] sram_mem [logic [31:0]];
    logic [31:0] ref_mem  [logic [31:0]];

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic logic [31:0] sram_rd(input logic [31:0] a);
        return sram_mem.exists(a) ? sram_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endfunction

    // Behavioural synchronous SRAM, write-then-read ordering.
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_wen != 4'h0)
                sram_mem[sram_addr] = merge(sram_rd(sram_addr), sram_wdata, sram_wen);
            else
                sram_rdata <= sram_rd(sram_addr);
        end
    end

    typedef struct {
        logic        is_inst;
        logic [31:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] exp_ih = '0;
    logic [31:0] exp_dh = '0;

    // Scoreboard: push on observed grant, pop on the following cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            sbq.delete();
            exp_ih = '0;
            exp_dh = '0;
            chk("rst_inst_rvalid", 32'(inst_rvalid), 0);
            chk("rst_data_rvalid", 32'(data_rvalid), 0);
            chk("rst_inst_rdata", inst_rdata, 0);
            chk("rst_data_rdata", data_rdata, 0);
            chk("rst_sram_en", 32'(sram_en), 0);
        end else begin
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                if (e.is_inst) begin
                    chk("sb_inst_rvalid", 32'(inst_rvalid), 1);
                    chk("sb_data_rvalid_quiet", 32'(data_rvalid), 0);
                    exp_ih = e.data;
                end else begin
                    chk("sb_data_rvalid", 32'(data_rvalid), 1);
                    chk("sb_inst_rvalid_quiet", 32'(inst_rvalid), 0);
                    exp_dh = e.data;
                end
            end else begin
                chk("sb_inst_rvalid_idle", 32'(inst_rvalid), 0);
                chk("sb_data_rvalid_idle", 32'(data_rvalid), 0);
            end
            chk("sb_inst_rdata", inst_rdata, exp_ih);
            chk("sb_data_rdata", data_rdata, exp_dh);
            chk("sb_one_grant", 32'(inst_gnt & data_gnt), 0);
            if (inst_gnt)
                sbq.push_back('{1'b1, ref_rd(inst_addr)});
            if (data_gnt) begin
                if (data_wen != 4'h0)
                    ref_mem[data_addr] = merge(ref_rd(data_addr), data_wdata, data_wen);
                else
                    sbq.push_back('{1'b0, ref_rd(data_addr)});
            end
        end
    end

    typedef struct {
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  wen;
        logic [31:0] daddr;
        logic [31:0] wdata;
        logic        e_ig;
        logic        e_dg;
        logic        e_stall;
    } vec_t;

    vec_t vecs[10];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic ir, input logic [31:0] ia,
                         input logic dr, input logic [3:0] we,
                         input logic [31:0] da, input logic [31:0] wd);
        inst_req   = ir;
        inst_addr  = ia;
        data_req   = dr;
        data_wen   = we;
        data_addr  = da;
        data_wdata = wd;
    endtask

    initial begin
        int k;
        vecs[0] = '{0, 32'h000, 0, 4'h0, 32'h000, 32'h0, 0, 0, 0};
        vecs[1] = '{1, 32'h104, 0, 4'h0, 32'h000, 32'h0, 1, 0, 0};
        vecs[2] = '{0, 32'h000, 1, 4'h0, 32'h300, 32'h0, 0, 1, 0};
        vecs[3] = '{0, 32'h000, 1, 4'hF, 32'h500, 32'h11223344, 0, 1, 0};
        vecs[4] = '{1, 32'h108, 1, 4'h0, 32'h500, 32'h0, 0, 1, 1};
        vecs[5] = '{1, 32'h108, 1, 4'h0, 32'h200, 32'h0, 0, 1, 1};
        vecs[6] = '{1, 32'h108, 0, 4'h0, 32'h000, 32'h0, 1, 0, 0};
        vecs[7] = '{1, 32'h10C, 1, 4'h8, 32'h600, 32'hCC000000, 0, 1, 1};
        vecs[8] = '{1, 32'h10C, 0, 4'h0, 32'h000, 32'h0, 1, 0, 0};
        vecs[9] = '{0, 32'h000, 1, 4'h0, 32'h600, 32'h0, 0, 1, 0};

        sram_mem[32'h100] = 32'hDEADBEEF; ref_mem[32'h100] = 32'hDEADBEEF;
        sram_mem[32'h104] = 32'h0BADF00D; ref_mem[32'h104] = 32'h0BADF00D;
        sram_mem[32'h108] = 32'hCAFEF00D; ref_mem[32'h108] = 32'hCAFEF00D;
        sram_mem[32'h200] = 32'h12345678; ref_mem[32'h200] = 32'h12345678;
        sram_mem[32'h300] = 32'hFFFFFFFF; ref_mem[32'h300] = 32'hFFFFFFFF;
        sram_mem[32'h600] = 32'h00ABCDEF; ref_mem[32'h600] = 32'h00ABCDEF;

        // Reset held with both requesting: everything quiet.
        rst = 1'b0;
        drive(1, 32'h100, 1, 4'h0, 32'h200, 32'h0);
        step();
        @(negedge clk);
        chk("reset_inst_gnt", 32'(inst_gnt), 0);
        chk("reset_data_gnt", 32'(data_gnt), 0);
        chk("reset_stallreq", 32'(stallreq), 0);
        chk("reset_sram_addr", sram_addr, 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("release_data_gnt", 32'(data_gnt), 1);
        chk("release_inst_gnt", 32'(inst_gnt), 0);
        step();
        drive(1, 32'h100, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("release_inst_gnt2", 32'(inst_gnt), 1);
        step();
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // Single fetch with hold.
        drive(1, 32'h100, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("fetch_gnt", 32'(inst_gnt), 1);
        chk("fetch_sram_addr", sram_addr, 32'h100);
        step();
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("fetch_rvalid", 32'(inst_rvalid), 1);
        chk("fetch_rdata", inst_rdata, 32'hDEADBEEF);
        repeat (4) step();
        @(negedge clk);
        chk("fetch_hold_rvalid", 32'(inst_rvalid), 0);
        chk("fetch_hold_rdata", inst_rdata, 32'hDEADBEEF);
        step();

        // Conflict: data first, fetch next cycle.
        drive(1, 32'h104, 1, 4'h0, 32'h200, 32'h0);
        @(negedge clk);
        chk("conf_data_gnt", 32'(data_gnt), 1);
        chk("conf_inst_gnt", 32'(inst_gnt), 0);
        chk("conf_stallreq", 32'(stallreq), 1);
        step();
        drive(1, 32'h104, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("conf_inst_gnt2", 32'(inst_gnt), 1);
        chk("conf_data_rvalid", 32'(data_rvalid), 1);
        chk("conf_data_rdata", data_rdata, 32'h12345678);
        step();
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("conf_inst_rvalid", 32'(inst_rvalid), 1);
        chk("conf_inst_rdata", inst_rdata, 32'h0BADF00D);
        step();

        // Starvation: fetch wins every fifth cycle.
        k = 0;
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'h108, 1, 4'h0, 32'h400 + 32'(4 * k), 32'h0);
            @(negedge clk);
            chk($sformatf("starve_inst_gnt_%0d", i), 32'(inst_gnt),
                32'((i % 5) == 4));
            chk($sformatf("starve_data_gnt_%0d", i), 32'(data_gnt),
                32'((i % 5) != 4));
            if ((i % 5) != 4) k++;
            step();
        end
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        step();

        // Partial write then read of same word.
        drive(0, 32'h0, 1, 4'b0011, 32'h300, 32'hAAAA5555);
        @(negedge clk);
        chk("wr_data_gnt", 32'(data_gnt), 1);
        chk("wr_sram_wen", 32'(sram_wen), 32'h3);
        step();
        drive(0, 32'h0, 1, 4'h0, 32'h300, 32'h0);
        @(negedge clk);
        chk("wr_no_rvalid", 32'(data_rvalid), 0);
        chk("rd_data_gnt", 32'(data_gnt), 1);
        step();
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("rd_rvalid", 32'(data_rvalid), 1);
        chk("rd_rdata", data_rdata, 32'hFFFF5555);
        step();

        // Reset while a fetch read is outstanding.
        drive(1, 32'h100, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mid_inst_gnt", 32'(inst_gnt), 1);
        step();
        rst = 1'b0;
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("mid_rvalid_t1", 32'(inst_rvalid), 0);
        chk("mid_rdata_t1", inst_rdata, 0);
        step();
        @(negedge clk);
        chk("mid_rvalid_t2", 32'(inst_rvalid), 0);
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("mid_hold_cleared", inst_rdata, 0);
        chk("mid_rvalid_after", 32'(inst_rvalid), 0);
        step();

        // Arbitration vector table.
        foreach (vecs[i]) begin
            drive(vecs[i].ireq, vecs[i].iaddr, vecs[i].dreq, vecs[i].wen,
                  vecs[i].daddr, vecs[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_inst_gnt", i), 32'(inst_gnt), 32'(vecs[i].e_ig));
            chk($sformatf("vec%0d_data_gnt", i), 32'(data_gnt), 32'(vecs[i].e_dg));
            chk($sformatf("vec%0d_stallreq", i), 32'(stallreq), 32'(vecs[i].e_stall));
            chk($sformatf("vec%0d_sram_en", i), 32'(sram_en),
                32'(vecs[i].e_ig | vecs[i].e_dg));
            chk($sformatf("vec%0d_sram_wen", i), 32'(sram_wen),
                vecs[i].e_dg ? 32'(vecs[i].wen) : 32'h0);
            chk($sformatf("vec%0d_sram_addr", i), sram_addr,
                vecs[i].e_dg ? vecs[i].daddr :
                vecs[i].e_ig ? vecs[i].iaddr : 32'h0);
            step();
        end
        drive(0, 32'h0, 0, 4'h0, 32'h0, 32'h0);
        @(negedge clk);
        chk("final_data_rdata", data_rdata, 32'hCCABCDEF);
        repeat (3) step();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
